dff_reg_arbiter: RTL and testbench

- Shares one WIDTH-bit register, built from dff_proc-style flops, between NUM_REQ requesters.
- Each requester asks for one of four operations: LOAD, CLEAR, PRESET or NOP.
- A round-robin arbiter grants one request at a time and an FSM applies it; the result drives q.
- Sits between software-visible control agents and the shared state register.

---
 rtl/dff_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/dff_reg_arbiter.sv | 120 ++++++++++++
 tb/tb_dff_reg_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared types for the dff_reg_arbiter block.
//   dff_op_e    - operation a requester asks to apply to the shared register.
//   arb_state_e - arbiter FSM state (IDLE: waiting/granting, EXEC: applying).
package dff_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_PRESET = 2'b11
    } dff_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational winner selection for dff_reg_arbiter.
//   req       [NUM_REQ-1:0] in  : request vector (one bit per requester)
//   rr_ptr    [IDW-1:0]     in  : index that has highest priority this cycle
//   winner    [IDW-1:0]     out : first set request scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ
//   any_valid               out : at least one request is set
// Config macro DFF_ARB_FIXED_PRIO_EN: when defined the scan always starts at
// index 0 (lowest index wins) and rr_ptr is ignored.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     winner,
    output logic               any_valid
);

`ifdef DFF_ARB_FIXED_PRIO_EN
    // Pointer is meaningless in fixed-priority mode.
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;
`endif

    always_comb begin
        int start;
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
`ifdef DFF_ARB_FIXED_PRIO_EN
        start     = 0;
`else
        start     = int'(rr_ptr);
`endif
        // Modulo on the scan index keeps non-power-of-2 NUM_REQ from ever
        // producing an index >= NUM_REQ.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (start + off) % NUM_REQ;
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                winner    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: one WIDTH-bit register shared by NUM_REQ requesters.
// A grant is taken in IDLE, the latched op is applied in the single EXEC cycle.
//   clock, reset           in  : rising-edge clock, synchronous active-high reset
//   req_valid [NUM_REQ]    in  : per-requester request, held until req_ready
//   req_op    [2*NUM_REQ]  in  : slice i = NOP/LOAD/CLEAR/PRESET
//   req_data  [W*NUM_REQ]  in  : slice i = load data
//   req_ready [NUM_REQ]    out : one-hot completion pulse during EXEC
//   q         [WIDTH]      out : shared register
//   grant_id  [IDW]        out : current/last granted requester
//   busy                   out : FSM state bit (high in EXEC)
// Handshake: a requester presents valid/op/data and holds them until it sees
// req_ready high at a rising edge; op/data are latched at grant, so dropping
// valid after grant never cancels the op.
// Config macro DFF_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins),
// rr_ptr tied to 0. Default build is round-robin.
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         q,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    arb_state_e        state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    winner;
    logic              any_valid;
    dff_op_e           op_l;
    logic [WIDTH-1:0]  data_l;
    logic [1:0]        win_op;
    logic [WIDTH-1:0]  win_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign win_op   = req_op[2*winner +: 2];
    assign win_data = req_data[WIDTH*winner +: WIDTH];

    // busy is the FSM state made visible.
    assign busy = (state == ST_EXEC);

    // The completion pulse is suppressed while reset is asserted: the pending
    // op is discarded at that edge, so the requester must not be told it
    // completed and must keep its request up.
    always_comb begin
        req_ready = '0;
        if (state == ST_EXEC && !reset) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Control: FSM, grant index and latched op/data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            op_l     <= OP_NOP;
            data_l   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        op_l     <= dff_op_e'(win_op);
                        data_l   <= win_data;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shared register: only written from latched state, never from req_*.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (state == ST_EXEC) begin
            case (op_l)
                OP_LOAD:   q <= data_l;
                OP_CLEAR:  q <= '0;
                OP_PRESET: q <= '1;
                default:   q <= q;
            endcase
        end
    end

`ifdef DFF_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDW-1:0] next_ptr;

    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Priority moves to the requester after the one just served.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == ST_EXEC) begin
            rr_ptr <= next_ptr;
        end
    end
`endif

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed self-checking bench for dff_reg_arbiter.
// A transaction-level model predicts q/busy/grant_id/req_ready every cycle;
// directed sequences additionally pin literal values.
module tb_dff_reg_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int IDW     = 2;

    localparam logic [1:0] NOP    = 2'b00;
    localparam logic [1:0] LOAD   = 2'b01;
    localparam logic [1:0] CLEAR  = 2'b10;
    localparam logic [1:0] PRESET = 2'b11;

    // ---------------- clock / reset ----------------
    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [2*NUM_REQ-1:0]     req_op = '0;
    logic [WIDTH*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         q;
    logic [IDW-1:0]           grant_id;
    logic                     busy;

    always #5 clock = ~clock;

    dff_reg_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q         (q),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // Tracks the register value, whether an op is being applied, which
    // requester owns it and who has priority next.
    logic [WIDTH-1:0] m_q = '0;
    bit               m_exec = 1'b0;
    int               m_gid = 0;
    int               m_ptr = 0;
    logic [1:0]       m_op = NOP;
    logic [WIDTH-1:0] m_data = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_q = '0; m_exec = 1'b0; m_gid = 0; m_ptr = 0;
        end else if (m_exec) begin
            if (m_op == LOAD)   m_q = m_data;
            if (m_op == CLEAR)  m_q = '0;
            if (m_op == PRESET) m_q = '1;
            m_ptr  = (m_gid + 1) % NUM_REQ;
            m_exec = 1'b0;
        end else begin
            int start;
`ifdef DFF_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr;
`endif
            for (int k = 0; k < NUM_REQ; k++) begin
                int w;
                w = (start + k) % NUM_REQ;
                if (!m_exec && req_valid[w]) begin
                    m_exec = 1'b1;
                    m_gid  = w;
                    m_op   = req_op[2*w +: 2];
                    m_data = req_data[WIDTH*w +: WIDTH];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            check("model_q", q, m_q);
            check("model_busy", busy, m_exec);
            check("model_grant_id", grant_id, m_gid);
            check("model_ready", req_ready,
                  (m_exec && !reset) ? (32'd1 << m_gid) : 32'd0);
        end
    end

    // ---------------- driver tasks / scoreboard ----------------
    logic [WIDTH-1:0]   exp_q[$];
    int                 grants[$];
    int                 exp_g[$];
    logic [NUM_REQ-1:0] hold_mask = '0;

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic present(input int i, input logic [1:0] op, input logic [WIDTH-1:0] d);
        req_valid[i]               = 1'b1;
        req_op[2*i +: 2]           = op;
        req_data[WIDTH*i +: WIDTH] = d;
    endtask

    // Negedges until req_ready[i] is seen; -1 on timeout.
    task automatic wait_ready(input int i, output int lat);
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (req_ready[i]) begin
                lat = c;
                break;
            end
        end
    endtask

    // One full transaction from an idle arbiter; returns after the edge that updates q.
    task automatic do_req(input int i, input logic [1:0] op, input logic [WIDTH-1:0] d);
        int lat;
        present(i, op, d);
        wait_ready(i, lat);
        check("req_latency", lat, 1);
        @(posedge clock);
        #1 req_valid[i] = 1'b0;
    endtask

    // Serve pending requests, recording grant order and checking q after each op.
    task automatic serve(input int n_grants);
        int got;
        got = 0;
        for (int c = 0; c < 60 && got < n_grants; c++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                int w;
                w = 0;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) w = i;
                @(posedge clock);
                #1;
                grants.push_back(w);
                got++;
                if (exp_q.size() > 0) check("serve_q", q, exp_q.pop_front());
                if (!hold_mask[w]) req_valid[w] = 1'b0;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        check("serve_count", got, n_grants);
    endtask

    task automatic check_grants(input string name);
        check({name, "_len"}, grants.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < grants.size(); i++)
            check(name, grants[i], exp_g[i]);
        grants.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        @(posedge clock);
        chk_en = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;

        // Reset then idle.
        repeat (5) begin
            @(posedge clock);
            #1;
            check("idle_q", q, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", req_ready, 0);
        end

        // Single LOAD from requester 2.
        do_req(2, LOAD, 8'hA5);
        check("load_q", q, 8'hA5);
        check("load_gid", grant_id, 2);
        check("load_busy", busy, 0);

        // PRESET then CLEAR from requester 0.
        do_req(0, PRESET, 8'h00);
        check("preset_q", q, 8'hFF);
        do_req(0, CLEAR, 8'h5A);
        check("clear_q", q, 8'h00);

        // NOP leaves q alone but still takes a grant.
        do_req(1, LOAD, 8'h5A);
        do_req(3, NOP, 8'h77);
        check("nop_q", q, 8'h5A);
        check("nop_gid", grant_id, 3);

        // Four-way contention from pointer 0.
        do_reset(1);
        for (int i = 0; i < NUM_REQ; i++) present(i, LOAD, 8'h10 + 8'(i));
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        serve(4);
        exp_g = '{0, 1, 2, 3};
        check_grants("contention_order");
        check("contention_q", q, 8'h13);
        check("contention_drained", req_valid, 0);

        // After 3 is served, pointer has wrapped to 0: 0 beats 2.
        present(2, LOAD, 8'h22);
        present(0, LOAD, 8'h20);
        exp_q = '{8'h20, 8'h22};
        serve(2);
        exp_g = '{0, 2};
        check_grants("wrap_order");

        // Requesters 0 and 3 both hold their requests across four grants.
        do_reset(1);
        hold_mask = 4'b1001;
        present(0, LOAD, 8'h55);
        present(3, LOAD, 8'h66);
`ifdef DFF_ARB_FIXED_PRIO_EN
        exp_q = '{8'h55, 8'h55, 8'h55, 8'h55};
        exp_g = '{0, 0, 0, 0};
`else
        exp_q = '{8'h55, 8'h66, 8'h55, 8'h66};
        exp_g = '{0, 3, 0, 3};
`endif
        serve(4);
        hold_mask = '0;
        req_valid = '0;
        check_grants("hold_order");

        // Reset arrives during EXEC of requester 1's LOAD.
        present(1, LOAD, 8'h3C);
        @(posedge clock);
        #1;
        check("mid_busy", busy, 1);
        check("mid_gid", grant_id, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_no_ready", req_ready, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        check("mid_q", q, 0);
        check("mid_idle", busy, 0);
        wait_ready(1, lat);
        check("reissue_latency", lat, 1);
        @(posedge clock);
        #1 req_valid[1] = 1'b0;
        check("reissue_q", q, 8'h3C);
        check("reissue_gid", grant_id, 1);

        repeat (3) @(posedge clock);
        #1;
        check("final_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
